// File: rtl/one_two_demux16_buf_pkg.sv
// Shared types and sizing for the 1-to-2 buffered demux.
package one_two_demux16_buf_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int CNT_W     = 16;
  localparam int NUM_SIDES = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;
endpackage

// File: rtl/one_two_demux16_buf_slot.sv
// Single-entry output slot for one demux side.
// Holds the word, tracks its EMPTY/FULL state and counts deliveries.
module demux_slot
  import one_two_demux16_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic             can_take,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic [CNT_W-1:0] cnt
);
  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deliver;

  assign deliver = (state_q == FULL) && q_ready;

  // A load while delivering keeps the slot FULL, so load wins over drain.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (ld)
      state_d = FULL;
    else if (deliver)
      state_d = EMPTY;
    if (ld)
      data_d = d;
    if (deliver)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign can_take = (state_q == EMPTY) || q_ready;
  assign q        = data_q;
  assign q_valid  = (state_q == FULL);
  assign cnt      = cnt_q;
endmodule

// File: rtl/one_two_demux16_buf.sv
// 1-to-2 demux with a registered single-entry slot per side.
// select=1 steers to q1 (slot 0), select=0 steers to q2 (slot 1).
module one_two_demux16_buf
  import one_two_demux16_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             select,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic             q1_valid,
  output logic             q2_valid,
  input  logic             q1_ready,
  input  logic             q2_ready,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);
  logic [NUM_SIDES-1:0]            ld_vec, take_vec, vld_vec, rdy_vec;
  logic [NUM_SIDES-1:0][WIDTH-1:0] q_arr;
  logic [NUM_SIDES-1:0][CNT_W-1:0] cnt_arr;
  logic                            sel_idx;
  logic                            accept;

  assign sel_idx = ~select;
  assign rdy_vec = {q2_ready, q1_ready};

  // Only the selected slot feeds in_ready; reset gates it low.
  always_comb begin
    in_ready = ~reset & take_vec[sel_idx];
    accept   = in_valid & in_ready;
    ld_vec   = '0;
    ld_vec[sel_idx] = accept;
  end

  for (genvar i = 0; i < NUM_SIDES; i++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk      (clk),
      .rst      (reset),
      .ld       (ld_vec[i]),
      .d        (d),
      .can_take (take_vec[i]),
      .q        (q_arr[i]),
      .q_valid  (vld_vec[i]),
      .q_ready  (rdy_vec[i]),
      .cnt      (cnt_arr[i])
    );
  end

  assign q1       = q_arr[0];
  assign q2       = q_arr[1];
  assign q1_valid = vld_vec[0];
  assign q2_valid = vld_vec[1];
  assign cnt1     = cnt_arr[0];
  assign cnt2     = cnt_arr[1];
endmodule

// File: tb/tb_one_two_demux16_buf.sv
// Directed bench: stimulus pushes expected words per side, a monitor pops on each delivery.
module tb_one_two_demux16_buf;
  logic        clk = 1'b0;
  logic        reset;
  logic        select;
  logic [15:0] d;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] q1, q2;
  logic        q1_valid, q2_valid;
  logic        q1_ready, q2_ready;
  logic [15:0] cnt1, cnt2;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp1[$];
  logic [15:0] exp2[$];

  one_two_demux16_buf #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .select(select), .d(d),
    .in_valid(in_valid), .in_ready(in_ready),
    .q1(q1), .q2(q2), .q1_valid(q1_valid), .q2_valid(q2_valid),
    .q1_ready(q1_ready), .q2_ready(q2_ready),
    .cnt1(cnt1), .cnt2(cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one word; returns how many cycles it had to wait for in_ready.
  task automatic send(input logic sel, input logic [15:0] data, output int waits);
    bit done = 0;
    waits = 0;
    select = sel; d = data; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        if (sel) exp1.push_back(data); else exp2.push_back(data);
        done = 1;
      end else begin
        waits++;
        if (waits > 50) begin
          chk("accept_timeout", 32'(waits), 32'd0);
          done = 1;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic monitor_loop();
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (!reset && q1_valid && q1_ready) begin
        if (exp1.size() == 0) chk("q1_unexpected", 32'(q1), 32'hFFFF_FFFF);
        else begin e = exp1.pop_front(); chk("q1_data", 32'(q1), 32'(e)); end
      end
      if (!reset && q2_valid && q2_ready) begin
        if (exp2.size() == 0) chk("q2_unexpected", 32'(q2), 32'hFFFF_FFFF);
        else begin e = exp2.pop_front(); chk("q2_data", 32'(q2), 32'(e)); end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    fork monitor_loop(); join_none

    reset = 1'b1; select = 1'b1; d = '0; in_valid = 1'b0;
    q1_ready = 1'b1; q2_ready = 1'b1;
    #1;
    chk("rst_q1_valid", 32'(q1_valid), 0);
    chk("rst_q2_valid", 32'(q2_valid), 0);
    chk("rst_q1", 32'(q1), 0);
    chk("rst_q2", 32'(q2), 0);
    chk("rst_cnt1", 32'(cnt1), 0);
    chk("rst_cnt2", 32'(cnt2), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    idle(2);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Routing
    send(1'b1, 16'hA5A5, w);
    chk("route_q1_valid", 32'(q1_valid), 1);
    chk("route_q1", 32'(q1), 32'hA5A5);
    send(1'b0, 16'h5A5A, w);
    chk("route_q2_valid", 32'(q2_valid), 1);
    chk("route_q2", 32'(q2), 32'h5A5A);
    idle(1);
    chk("route_cnt1", 32'(cnt1), 1);
    chk("route_cnt2", 32'(cnt2), 1);

    // Independence: stalled q2 must not block q1
    q2_ready = 1'b0;
    send(1'b0, 16'h7777, w);
    select = 1'b0; #1;
    chk("indep_rdy_sel0", 32'(in_ready), 0);
    in_valid = 1'b1; #1;
    chk("indep_rdy_sel0_vld", 32'(in_ready), 0);
    in_valid = 1'b0;
    select = 1'b1; #1;
    chk("indep_rdy_sel1", 32'(in_ready), 1);
    send(1'b1, 16'h1234, w);
    chk("indep_q1", 32'(q1), 32'h1234);
    chk("indep_q2_hold", 32'(q2), 32'h7777);
    chk("indep_q2_valid", 32'(q2_valid), 1);
    q2_ready = 1'b1;
    idle(2);
    chk("indep_cnt1", 32'(cnt1), 2);
    chk("indep_cnt2", 32'(cnt2), 2);

    // Back-to-back on side 1
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 16'(i), w);
      chk("b2b_no_wait", 32'(w), 0);
    end
    idle(2);
    chk("b2b_cnt1", 32'(cnt1), 10);

    // Stall with BEEF held
    q1_ready = 1'b0;
    send(1'b1, 16'hBEEF, w);
    select = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_q1", 32'(q1), 32'hBEEF);
      chk("stall_valid", 32'(q1_valid), 1);
      chk("stall_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk); #1;
    q1_ready = 1'b1;
    idle(1);
    chk("stall_cnt1", 32'(cnt1), 11);
    chk("stall_drained", 32'(q1_valid), 0);

    // Reset with both slots full
    q1_ready = 1'b0; q2_ready = 1'b0;
    send(1'b1, 16'h1111, w);
    send(1'b0, 16'h2222, w);
    chk("pre_rst_full", 32'({q1_valid, q2_valid}), 32'b11);
    @(negedge clk); reset = 1'b1; #1;
    chk("mid_rst_valids", 32'({q1_valid, q2_valid}), 0);
    chk("mid_rst_q", 32'({q1, q2}), 0);
    chk("mid_rst_cnt", 32'({cnt1, cnt2}), 0);
    select = 1'b1; #1;
    chk("mid_rst_rdy1", 32'(in_ready), 0);
    select = 1'b0; #1;
    chk("mid_rst_rdy0", 32'(in_ready), 0);
    exp1.delete(); exp2.delete();
    q1_ready = 1'b1; q2_ready = 1'b1;
    @(negedge clk); reset = 1'b0;
    select = 1'b1; d = 16'h3333; in_valid = 1'b1; #1;
    chk("post_rst_ready", 32'(in_ready), 1);
    exp1.push_back(16'h3333);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post_rst_q1", 32'(q1), 32'h3333);
    idle(1);
    chk("post_rst_cnt1", 32'(cnt1), 1);

    // Counter wrap on side 2
    for (int i = 0; i < 65536; i++) send(1'b0, 16'(i), w);
    idle(2);
    chk("wrap_cnt2", 32'(cnt2), 0);
    chk("wrap_cnt1", 32'(cnt1), 1);

    chk("q1_queue_empty", 32'(exp1.size()), 0);
    chk("q2_queue_empty", 32'(exp2.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
